// File: rtl/muldiv_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
// Op encodings follow the EX-stage muldiv op field.
package muldiv_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_CNT_W = 5;

   localparam logic [XLEN-1:0] DIVZERO_LO = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DIVFIX
   } state_e;

   function automatic logic [XLEN-1:0] mag(
      input logic [XLEN-1:0] x,
      input logic            sgn
   );
      return (sgn && x[XLEN-1]) ? -x : x;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between EX forwarding, hazard control
// and the HI/LO unit.
interface muldiv_if;
   import muldiv_pkg::*;

   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, flush,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/mul32.sv
// Combinational 32x32 unsigned multiplier shared by the EX stage.
module mul32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] p
);

   assign p = 64'(a) * 64'(b);

endmodule

// File: rtl/muldiv_hilo_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step
   import muldiv_pkg::*;
(
   input  logic [XLEN:0]   rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN:0]   rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] sh;
   logic          ge;

   assign sh = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
   // full-width compare keeps the trial subtract honest for any remainder
   assign ge = {rem_i[XLEN], sh} >= {2'b00, dvs_i};

   assign rem_o = ge ? (sh - {1'b0, dvs_i}) : sh;
   assign quo_o = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO unit: sequences MULT/MULTU, iterative DIV/DIVU and MTHI/MTLO.
// Operands are held as magnitudes; sign is reapplied at writeback.
module muldiv_hilo
   import muldiv_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);

   state_e state_q, state_d;

   logic [XLEN-1:0]      hi_q, hi_d;
   logic [XLEN-1:0]      lo_q, lo_d;
   logic [XLEN-1:0]      a_q, a_d;
   logic [XLEN-1:0]      b_q, b_d;
   logic [XLEN:0]        rem_q, rem_d;
   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic                 rneg_q, rneg_d;
   logic                 done_q, done_d;

   logic [2*XLEN-1:0] prod;
   logic [XLEN:0]     rem_nxt;
   logic [XLEN-1:0]   quo_nxt;
   logic              sgn;
   logic              sx;

   mul32 u_mul (
      .a (a_q),
      .b (b_q),
      .p (prod)
   );

   div_step u_step (
      .rem_i (rem_q),
      .quo_i (a_q),
      .dvs_i (b_q),
      .rem_o (rem_nxt),
      .quo_o (quo_nxt)
   );

   assign sgn = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign sx  = sgn & (bus.rs_val[XLEN-1] ^ bus.rt_val[XLEN-1]);

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  OP_MTHI: begin
                     hi_d   = bus.rs_val;
                     done_d = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_d   = bus.rs_val;
                     done_d = 1'b1;
                  end
                  OP_MULT, OP_MULTU: begin
                     a_d     = mag(bus.rs_val, sgn);
                     b_d     = mag(bus.rt_val, sgn);
                     neg_d   = sx;
                     state_d = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (bus.rt_val == '0) begin
                        hi_d   = bus.rs_val;
                        lo_d   = DIVZERO_LO;
                        done_d = 1'b1;
                     end else begin
                        a_d     = mag(bus.rs_val, sgn);
                        b_d     = mag(bus.rt_val, sgn);
                        neg_d   = sx;
                        rneg_d  = sgn & bus.rs_val[XLEN-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            {hi_d, lo_d} = neg_q ? -prod : prod;
            done_d       = 1'b1;
            state_d      = S_IDLE;
         end
         S_DIV: begin
            rem_d = rem_nxt;
            a_d   = quo_nxt;
            cnt_d = cnt_q + DIV_CNT_W'(1);
            if (cnt_q == DIV_CNT_W'(XLEN-1))
               state_d = S_DIVFIX;
         end
         S_DIVFIX: begin
            lo_d    = neg_q ? -a_q : a_q;
            hi_d    = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase

      // flush wins over everything, including a start in IDLE
      if (bus.flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: directed cases plus random ops against
// a plain-arithmetic HI/LO model.
module tb_muldiv_hilo;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   muldiv_if bus ();

   muldiv_hilo dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h",
                  tag, obs, exp);
   endtask

   // Architectural model: updates m_hi/m_lo, returns busy cycles
   // and whether a done pulse is due.
   function automatic void model(input logic [2:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output int bz,
                                 output bit dn);
      longint sa, sb, p, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      bz = 0;
      dn = 1'b1;
      case (o)
         3'd0: begin
            p = sa * sb;
            m_hi = p[63:32]; m_lo = p[31:0]; bz = 1;
         end
         3'd1: begin
            up = {32'b0, a} * {32'b0, b};
            m_hi = up[63:32]; m_lo = up[31:0]; bz = 1;
         end
         3'd2, 3'd3: begin
            if (b == 0) begin
               m_hi = a; m_lo = 32'hFFFF_FFFF;
            end else begin
               if (o == 3'd2) begin
                  q = sa / sb; r = sa % sb;
               end else begin
                  q = longint'({32'b0, a}) / longint'({32'b0, b});
                  r = longint'({32'b0, a}) % longint'({32'b0, b});
               end
               m_lo = q[31:0]; m_hi = r[31:0]; bz = 33;
            end
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: dn = 1'b0;
      endcase
   endfunction

   task automatic run_op(input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input bit poke,
                         input string tag);
      int bz;
      bit dn;
      int busy_cnt = 0;
      int n = 0;
      int dones = 0;
      model(o, a, b, bz, dn);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o;
      bus.rs_val = a; bus.rt_val = b;
      @(negedge clk);
      bus.start = 1'b0;
      if (dn) begin
         while (!bus.done && n < 60) begin
            if (bus.busy) busy_cnt++;
            bus.start  = poke & bus.busy;
            bus.op     = 3'($urandom_range(0, 5));
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            @(negedge clk);
            n++;
         end
         bus.start = 1'b0;
         chk({tag, ".done"}, 64'(bus.done), 64'd1);
         chk({tag, ".busycyc"}, 64'(busy_cnt), 64'(bz));
         chk({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
         chk({tag, ".hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
         @(negedge clk);
         chk({tag, ".pulse"}, 64'(bus.done), 64'd0);
      end else begin
         repeat (4) begin
            dones += int'(bus.done);
            busy_cnt += int'(bus.busy);
            @(negedge clk);
         end
         chk({tag, ".nodone"}, 64'(dones), 64'd0);
         chk({tag, ".nobusy"}, 64'(busy_cnt), 64'd0);
         chk({tag, ".hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
      end
   endtask

   initial begin
      int dones;
      logic [2:0] ro;
      logic [31:0] ra, rb;
      bus.start = 1'b0; bus.op = '0; bus.flush = 1'b0;
      bus.rs_val = '0; bus.rt_val = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset.hilo", {bus.hi, bus.lo}, 64'd0);
      chk("reset.busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
      rst_n = 1'b1;

      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
      run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "mult_neg");
      run_op(3'd1, 32'd321, 32'd640, 1'b0, "multu_small");
      run_op(3'd2, 32'hFFFF_FF9C, 32'd7, 1'b1, "div_neg100");
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_intmin");
      run_op(3'd3, 32'hA5A5_A5A5, 32'd0, 1'b0, "divu_zero");
      run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, "mthi");
      run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0, "mtlo");
      run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, "unused_op");

      // flush mid-divide
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd3;
      bus.rs_val = 32'd1234567; bus.rt_val = 32'd89;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush.busy", 64'(bus.busy), 64'd0);
      dones = 0;
      repeat (40) begin
         dones += int'(bus.done);
         @(negedge clk);
      end
      chk("flush.nodone", 64'(dones), 64'd0);
      chk("flush.hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

      // flush alongside start in IDLE drops the start
      bus.start = 1'b1; bus.op = 3'd4; bus.rs_val = 32'h0BAD_F00D;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_start.done", 64'(bus.done), 64'd0);
      chk("flush_start.hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

      // async reset mid-divide
      bus.start = 1'b1; bus.op = 3'd3;
      bus.rs_val = 32'hFFFF_0000; bus.rt_val = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (18) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("areset.hilo", {bus.hi, bus.lo}, 64'd0);
      chk("areset.busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         run_op(ro, ra, rb, 1'($urandom_range(0, 1)), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
